beam_power_rbg_select: RTL
==========================

// Module: beam_power_rbg_select
// PURPOSE
// - Downstream of the per-RBG beam power stage. Consumes per-RBG |I|+|Q| beam sums and accumulates them per RBG across symbols.
// - On command, scans every RBG and reports the strongest beam index and its accumulated power.
// - Result feeds the beam-selection / dimension-reduction control path.
// PARAMETERS
// - BEAM     16  beams per RBG sum vector
// - IW       40  input sum width, unsigned
// - AW       44  accumulator width (IW + 4 bits headroom, 16 symbols)
// - RBG_MAX  64  accumulation buffer depth (RBGs); must be <= 256
// - BW       $clog2(BEAM)  beam index width (derived localparam)
// PORTS
// - i_clk        in   1          data clock
// - i_reset_n    in   1          asynchronous, active-low reset
// - i_symb_1st   in   1          level, held for the whole symbol: first symbol of window, overwrite instead of add
// - i_data_sum   in   BEAM*IW    per-beam RBG power sums
// - i_data_addr  in   8          RBG index of i_data_sum
// - i_data_vld   in   1          upstream valid
// - i_data_wen   in   1          write strobe; sum is taken only when vld&&wen
// - i_acc_done   in   1          pulse: window complete, start scan
// - i_rbg_total  in   8          RBGs to scan, sampled on the accepted i_acc_done
// - o_best_idx   out  BW         strongest beam of the current RBG
// - o_best_pwr   out  AW         accumulated power of o_best_idx
// - o_rbg_addr   out  8          RBG index of the result
// - o_vld        out  1          result valid
// - o_sop/o_eop  out  1          first/last result of a scan
// - o_done       out  1          1-cycle pulse, scan finished
// - o_busy       out  1          FSM not IDLE
// - o_wr_drop    out  1          1-cycle pulse, a write was discarded
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, pipeline valids 0. Buffer contents are not reset; the first window must use i_symb_1st.
// - Write path, 2-cycle read-modify-write. Cycle 0: read mem[a]. Cycle 1: mem[a] <= i_symb_1st_q ? sum : mem[a]+sum, per beam.
//   - Sum is zero-extended IW->AW.
//   - Back-to-back writes to the same address are forwarded from the cycle-1 result. No stall, no lost update.
// - Write is dropped, with o_wr_drop pulsed in the accept cycle, when: a >= RBG_MAX, or FSM != IDLE.
// - FSM states:
//   - IDLE: i_acc_done -> SCAN with r=0 and N=i_rbg_total. If N==0, stay IDLE, pulse o_done next cycle, no o_vld.
//   - SCAN: issue one read of mem[r] per cycle, r++. After r==N-1 -> DRAIN. r wraps never; N > RBG_MAX is clamped to RBG_MAX.
//   - DRAIN: wait until the compare pipeline is empty, pulse o_done, -> IDLE.
// - i_acc_done outside IDLE is ignored. A write accepted in the same cycle as i_acc_done in IDLE completes before the first scan read.
// - Compare tree: pairwise max over BEAM entries, registered at every level.
//   - Tie goes to the lower beam index.
//   - Latency from scan read issue to o_vld = 1 + BW cycles (5 at defaults).
//   - One result per cycle, in address order 0..N-1.
// - o_sop with the result for r=0; o_eop with r=N-1 (both high when N==1).
// - o_busy is high from the cycle after the accepted i_acc_done until the o_done cycle inclusive.
// - Async reset mid-scan: FSM -> IDLE, pipeline flushed, no o_done. Buffer contents are undefined for the next window.
// CONFIGURATION
// - BEAM_PWR_SAT_EN defined: accumulate saturates at 2^AW-1 per beam.
// - BEAM_PWR_SAT_EN undefined: modulo-2^AW wrap. o_best_pwr then carries no overflow indication.
// TESTING
// - Single symbol, i_symb_1st=1, RBG 0..3, beam k = 100*(k+1), then i_acc_done with N=4
//   -> 4 results, idx=15, pwr=1600, sop on addr 0, eop on addr 3, o_vld 5 cycles after the first scan read, o_done after the eop.
// - 3 symbols, RBG 2 beam 7 = 1000 each symbol, others 10
//   -> idx=7, pwr=3000 (first symbol overwrote the stale buffer).
// - Back-to-back writes to addr 5 on consecutive cycles, 50 then 70, not first symbol, prior 0
//   -> scan shows 120 (forwarding).
// - Ties: all beams equal 42 -> idx=0. Write to addr 64 -> o_wr_drop=1, buffer unchanged.
// - Write during SCAN -> o_wr_drop. i_acc_done during SCAN ignored. N=0 -> o_done only.
//   Reset asserted at scan result 2 -> outputs 0, no o_done.
// - All beams at IW max for 17 symbols: with BEAM_PWR_SAT_EN pwr = 2^44-1; without it pwr = (17*(2^40-1)) mod 2^44.

Source files
------------

// File: rtl/beam_power_rbg_select.sv
// Per-RBG beam power accumulator with a pipelined strongest-beam scan.
// Optional macro BEAM_PWR_SAT_EN: saturating accumulate instead of modulo-2^AW wrap.

module bprs_acc_lane #(
  parameter int IW = 40,
  parameter int AW = 44
) (
  input  logic [AW-1:0] old_i,
  input  logic [IW-1:0] sum_i,
  input  logic          first_i,
  output logic [AW-1:0] new_o
);
  logic [AW-1:0] sum_x;
  assign sum_x = AW'(sum_i);
`ifdef BEAM_PWR_SAT_EN
  logic [AW:0] acc;
  assign acc   = {1'b0, old_i} + {1'b0, sum_x};
  assign new_o = first_i ? sum_x : (acc[AW] ? '1 : acc[AW-1:0]);
`else
  assign new_o = first_i ? sum_x : old_i + sum_x;
`endif
endmodule

module beam_power_rbg_select #(
  parameter int BEAM    = 16,
  parameter int IW      = 40,
  parameter int AW      = 44,
  parameter int RBG_MAX = 64
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_symb_1st,
  input  logic [BEAM*IW-1:0]      i_data_sum,
  input  logic [7:0]              i_data_addr,
  input  logic                    i_data_vld,
  input  logic                    i_data_wen,
  input  logic                    i_acc_done,
  input  logic [7:0]              i_rbg_total,
  output logic [$clog2(BEAM)-1:0] o_best_idx,
  output logic [AW-1:0]           o_best_pwr,
  output logic [7:0]              o_rbg_addr,
  output logic                    o_vld,
  output logic                    o_sop,
  output logic                    o_eop,
  output logic                    o_done,
  output logic                    o_busy,
  output logic                    o_wr_drop
);
  localparam int BW    = $clog2(BEAM);
  localparam int AD    = (RBG_MAX > 1) ? $clog2(RBG_MAX) : 1;
  localparam int NODES = 2*BEAM - 1;
  localparam logic [8:0] RBG_MAX9 = 9'(RBG_MAX);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;
  typedef logic [BEAM-1:0][AW-1:0] vec_t;

  // Tree nodes are stored level by level: leaves at 0..BEAM-1, root at NODES-1.
  function automatic int lvl_off(input int lv);
    return 2*BEAM - ((2*BEAM) >> lv);
  endfunction

  state_e state_q, state_d;
  logic [7:0] r_q, r_d, n_q, n_d, n_clamp;
  logic       zero_done_q, zero_done_d, drain_done, issue;

  logic [BEAM-1:0][IW-1:0] sum_in, wr1_sum_q;
  logic                    wr_req, wr_drop, wr_acc;
  logic [AD-1:0]           wr_addr, wr1_addr_q, scan_addr;
  logic                    wr1_vld_q, wr1_first_q;
  vec_t                    wr1_old_q, wr1_new, wr_old_d, scan_rd;
  vec_t                    mem_q [RBG_MAX];

  logic [NODES-1:0][AW-1:0] node_pwr_q;
  logic [NODES-1:0][BW-1:0] node_idx_q;
  logic [BW:0]              vld_pipe_q, sop_pipe_q, eop_pipe_q;
  logic [BW:0][7:0]         addr_pipe_q;

  assign sum_in  = i_data_sum;
  assign wr_req  = i_data_vld & i_data_wen;
  assign wr_drop = wr_req & (({1'b0, i_data_addr} >= RBG_MAX9) | (state_q != IDLE));
  assign wr_acc  = wr_req & ~wr_drop;
  assign wr_addr = i_data_addr[AD-1:0];

  // The cycle-1 result is not in mem yet, so a same-address read must take it directly.
  assign wr_old_d  = (wr1_vld_q && wr1_addr_q == wr_addr) ? wr1_new : mem_q[wr_addr];
  assign scan_addr = r_q[AD-1:0];
  assign scan_rd   = (wr1_vld_q && wr1_addr_q == scan_addr) ? wr1_new : mem_q[scan_addr];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr1_vld_q   <= 1'b0;
      wr1_first_q <= 1'b0;
      wr1_addr_q  <= '0;
      wr1_sum_q   <= '0;
      wr1_old_q   <= '0;
    end else begin
      wr1_vld_q <= wr_acc;
      if (wr_acc) begin
        wr1_first_q <= i_symb_1st;
        wr1_addr_q  <= wr_addr;
        wr1_sum_q   <= sum_in;
        wr1_old_q   <= wr_old_d;
      end
    end
  end

  for (genvar b = 0; b < BEAM; b++) begin : g_lane
    bprs_acc_lane #(.IW(IW), .AW(AW)) u_lane (
      .old_i   (wr1_old_q[b]),
      .sum_i   (wr1_sum_q[b]),
      .first_i (wr1_first_q),
      .new_o   (wr1_new[b])
    );
  end

  always_ff @(posedge i_clk) begin
    if (wr1_vld_q) mem_q[wr1_addr_q] <= wr1_new;
  end

  assign n_clamp = ({1'b0, i_rbg_total} > RBG_MAX9) ? RBG_MAX9[7:0] : i_rbg_total;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      n_q         <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      n_q         <= n_d;
      zero_done_q <= zero_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    n_d         = n_q;
    issue       = 1'b0;
    drain_done  = 1'b0;
    zero_done_d = 1'b0;
    unique case (state_q)
      IDLE: if (i_acc_done) begin
        if (n_clamp == 8'd0) zero_done_d = 1'b1;
        else begin
          state_d = SCAN;
          r_d     = '0;
          n_d     = n_clamp;
        end
      end
      SCAN: begin
        issue = 1'b1;
        r_d   = r_q + 8'd1;
        if (r_q == n_q - 8'd1) state_d = DRAIN;
      end
      DRAIN: if (vld_pipe_q == '0) begin
        drain_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage k of the pipe holds tree level k; ties keep the left (lower-index) child.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vld_pipe_q  <= '0;
      sop_pipe_q  <= '0;
      eop_pipe_q  <= '0;
      addr_pipe_q <= '0;
      node_pwr_q  <= '0;
      node_idx_q  <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[BW-1:0], issue};
      if (issue) begin
        sop_pipe_q[0]  <= (r_q == 8'd0);
        eop_pipe_q[0]  <= (r_q == n_q - 8'd1);
        addr_pipe_q[0] <= r_q;
        for (int j = 0; j < BEAM; j++) begin
          node_pwr_q[j] <= scan_rd[j];
          node_idx_q[j] <= BW'(j);
        end
      end
      for (int lv = 1; lv <= BW; lv++) begin
        if (vld_pipe_q[lv-1]) begin
          sop_pipe_q[lv]  <= sop_pipe_q[lv-1];
          eop_pipe_q[lv]  <= eop_pipe_q[lv-1];
          addr_pipe_q[lv] <= addr_pipe_q[lv-1];
          for (int j = 0; j < (BEAM >> lv); j++) begin
            if (node_pwr_q[lvl_off(lv-1)+2*j+1] > node_pwr_q[lvl_off(lv-1)+2*j]) begin
              node_pwr_q[lvl_off(lv)+j] <= node_pwr_q[lvl_off(lv-1)+2*j+1];
              node_idx_q[lvl_off(lv)+j] <= node_idx_q[lvl_off(lv-1)+2*j+1];
            end else begin
              node_pwr_q[lvl_off(lv)+j] <= node_pwr_q[lvl_off(lv-1)+2*j];
              node_idx_q[lvl_off(lv)+j] <= node_idx_q[lvl_off(lv-1)+2*j];
            end
          end
        end
      end
    end
  end

  assign o_vld      = vld_pipe_q[BW];
  assign o_sop      = vld_pipe_q[BW] & sop_pipe_q[BW];
  assign o_eop      = vld_pipe_q[BW] & eop_pipe_q[BW];
  assign o_rbg_addr = addr_pipe_q[BW];
  assign o_best_idx = node_idx_q[NODES-1];
  assign o_best_pwr = node_pwr_q[NODES-1];
  assign o_done     = drain_done | zero_done_q;
  assign o_busy     = (state_q != IDLE);
  assign o_wr_drop  = wr_drop;

endmodule
